// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared FU/CDB packet types and arbiter sizing
package cdb_arbiter_pkg;

  localparam int NUM_FU   = 6;
  localparam int N_CDB    = 1;
  localparam int PRIO_FU  = 3;
  localparam int ROB_SZ   = 32;
  localparam int FU_IDX_W = $clog2(NUM_FU + 1);

  typedef logic [$clog2(ROB_SZ)-1:0] ROB_TAG;
  typedef logic [FU_IDX_W-1:0]       fu_idx_t;

  typedef struct packed {
    logic        done;
    ROB_TAG      rob_tag;
    logic [31:0] result;
    logic        take_branch;
    logic [31:0] branch_loc;
  } FU_OUT_PACKET;

  typedef struct packed {
    FU_OUT_PACKET [NUM_FU:0] fu_out_packets;
  } EX_CDB_PACKET;

  typedef struct packed {
    logic [NUM_FU:0] ack;
  } CDB_EX_PACKET;

  typedef struct packed {
    logic        valid;
    ROB_TAG      rob_tag;
    logic [31:0] value;
  } CDB_PACKET;

  // FU indices run 1..NUM_FU; index 0 is never a real unit.
  function automatic fu_idx_t next_fu(input fu_idx_t i);
    return (i >= fu_idx_t'(NUM_FU)) ? fu_idx_t'(1) : i + fu_idx_t'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rtl/cdb_arbiter_rr_pick.sv - rotating first-N requester selector, one-hot grant per slot
module rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SLOTS = 1
) (
  input  logic [NUM_FU:0]               req,
  input  fu_idx_t                       ptr,
  input  logic [NUM_FU:0]               mask,
  output logic [N_SLOTS-1:0][NUM_FU:0]  grant
);

  int      cnt;
  fu_idx_t idx;

  // Walk every FU once starting at ptr; mask bits are excluded from the rotation.
  always_comb begin
    grant = '0;
    cnt   = 0;
    idx   = ptr;
    for (int k = 0; k < NUM_FU; k++) begin
      if (req[idx] && !mask[idx]) begin
        for (int s = 0; s < N_SLOTS; s++) begin
          if (cnt == s) grant[s][idx] = 1'b1;
        end
        cnt = cnt + 1;
      end
      idx = next_fu(idx);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - grants held FU results onto the registered common data bus
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_CDB   = cdb_arbiter_pkg::N_CDB,
  parameter int PRIO_FU = cdb_arbiter_pkg::PRIO_FU
) (
  input  logic                   clock,
  input  logic                   reset,
  input  EX_CDB_PACKET           ex_cdb_packet,
  input  logic                   squash,
  output CDB_EX_PACKET           cdb_ex_packet,
  output CDB_PACKET [N_CDB-1:0]  cdb_packet,
  output logic                   cdb_busy
);

  logic [NUM_FU:0]              req;
  logic [NUM_FU:0]              mask;
  logic [NUM_FU:0]              ack;
  logic                         prio_req;
  logic                         arb_en;
  fu_idx_t                      rr_ptr;
  logic [N_CDB-1:0][NUM_FU:0]   rr_grant;
  logic [N_CDB-1:0][NUM_FU:0]   slot_grant;
  logic                         rr_used;
  fu_idx_t                      rr_last;
  CDB_PACKET [N_CDB-1:0]        cdb_next;
  logic                         busy_next;

  always_comb begin
    req = '0;
    for (int i = 1; i <= NUM_FU; i++) req[i] = ex_cdb_packet.fu_out_packets[i].done;
  end

  // The priority FU never competes in the rotation, so it can never be granted twice.
  always_comb begin
    mask          = '0;
    mask[0]       = 1'b1;
    mask[PRIO_FU] = 1'b1;
  end

  assign prio_req = (PRIO_FU != 0) && req[PRIO_FU];
  assign arb_en   = reset && !squash;

  rr_pick #(.N_SLOTS(N_CDB)) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .mask  (mask),
    .grant (rr_grant)
  );

  always_comb begin
    slot_grant = '0;
    if (arb_en) begin
      if (prio_req) begin
        slot_grant[0][PRIO_FU] = 1'b1;
        for (int k = 1; k < N_CDB; k++) slot_grant[k] = rr_grant[k-1];
      end else begin
        slot_grant = rr_grant;
      end
    end
  end

  // Round-robin slots are filled in rotation order, so the last hit is the last RR grant.
  always_comb begin
    rr_used = 1'b0;
    rr_last = rr_ptr;
    ack     = '0;
    for (int k = 0; k < N_CDB; k++) begin
      ack = ack | slot_grant[k];
      for (int i = 1; i <= NUM_FU; i++) begin
        if (slot_grant[k][i] && !(i == PRIO_FU)) begin
          rr_used = 1'b1;
          rr_last = fu_idx_t'(i);
        end
      end
    end
  end

  always_comb begin
    cdb_next = '0;
    for (int k = 0; k < N_CDB; k++) begin
      for (int i = 1; i <= NUM_FU; i++) begin
        if (slot_grant[k][i]) begin
          cdb_next[k].valid   = 1'b1;
          cdb_next[k].rob_tag = ex_cdb_packet.fu_out_packets[i].rob_tag;
          cdb_next[k].value   = ex_cdb_packet.fu_out_packets[i].result;
        end
      end
    end
  end

  assign busy_next         = arb_en && ((req & ~ack) != '0);
  assign cdb_ex_packet.ack = ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_packet <= '0;
      cdb_busy   <= 1'b0;
      rr_ptr     <= fu_idx_t'(1);
    end else begin
      cdb_packet <= cdb_next;
      cdb_busy   <= busy_next;
      if (rr_used) rr_ptr <= next_fu(rr_last);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector bench for cdb_arbiter in three configurations
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic          clock;
  logic          reset;
  logic          squash;
  EX_CDB_PACKET  ex;
  CDB_EX_PACKET  ack0, ack1, ack2;
  CDB_PACKET [0:0] cdb0, cdb1;
  CDB_PACKET [1:0] cdb2;
  logic          busy0, busy1, busy2;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] res [7];

  // d0: one slot, FU3 priority; d1: one slot, no priority; d2: two slots, FU3 priority
  cdb_arbiter #(.N_CDB(1), .PRIO_FU(3)) d0 (
    .clock(clock), .reset(reset), .ex_cdb_packet(ex), .squash(squash),
    .cdb_ex_packet(ack0), .cdb_packet(cdb0), .cdb_busy(busy0));
  cdb_arbiter #(.N_CDB(1), .PRIO_FU(0)) d1 (
    .clock(clock), .reset(reset), .ex_cdb_packet(ex), .squash(squash),
    .cdb_ex_packet(ack1), .cdb_packet(cdb1), .cdb_busy(busy1));
  cdb_arbiter #(.N_CDB(2), .PRIO_FU(3)) d2 (
    .clock(clock), .reset(reset), .ex_cdb_packet(ex), .squash(squash),
    .cdb_ex_packet(ack2), .cdb_packet(cdb2), .cdb_busy(busy2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] done;
    logic       sq;
    logic [6:0] ack0;
    logic [6:0] ack1;
    logic       busy0;
    logic       busy1;
  } vec_t;

  vec_t vt [15];

  function automatic ROB_TAG tag_of(input int i);
    return ROB_TAG'(i * 3 + 1);
  endfunction

  function automatic int idx_of(input logic [6:0] a);
    for (int i = 1; i < 7; i++) if (a[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string name, input CDB_PACKET act, input logic [6:0] a);
    int i;
    CDB_PACKET e;
    i = idx_of(a);
    if (a == 7'd0) begin
      chk({name, ".valid"}, 64'(act.valid), 64'd0);
    end else begin
      e.valid   = 1'b1;
      e.rob_tag = tag_of(i);
      e.value   = res[i];
      chk(name, 64'(act), 64'(e));
    end
  endtask

  task automatic apply(input logic [6:0] done);
    for (int i = 0; i < 7; i++) begin
      ex.fu_out_packets[i].done        = done[i];
      ex.fu_out_packets[i].rob_tag     = tag_of(i);
      ex.fu_out_packets[i].result      = res[i];
      ex.fu_out_packets[i].take_branch = 1'b0;
      ex.fu_out_packets[i].branch_loc  = 32'd0;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    squash = 1'b0;
    apply(7'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [6:0] done;
    int seq [3];

    for (int i = 0; i < 7; i++) res[i] = 32'hA000_0000 + 32'(i);
    vt[0]  = '{7'b1111110, 1'b0, 7'b0001000, 7'b0000010, 1'b1, 1'b1};
    vt[1]  = '{7'b1111110, 1'b0, 7'b0001000, 7'b0000100, 1'b1, 1'b1};
    vt[2]  = '{7'b1111110, 1'b0, 7'b0001000, 7'b0001000, 1'b1, 1'b1};
    vt[3]  = '{7'b1111110, 1'b0, 7'b0001000, 7'b0010000, 1'b1, 1'b1};
    vt[4]  = '{7'b1111110, 1'b0, 7'b0001000, 7'b0100000, 1'b1, 1'b1};
    vt[5]  = '{7'b1111110, 1'b0, 7'b0001000, 7'b1000000, 1'b1, 1'b1};
    vt[6]  = '{7'b1111110, 1'b0, 7'b0001000, 7'b0000010, 1'b1, 1'b1};
    vt[7]  = '{7'b0000000, 1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0};
    vt[8]  = '{7'b0000001, 1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0};
    vt[9]  = '{7'b0100100, 1'b1, 7'b0000000, 7'b0000000, 1'b0, 1'b0};
    vt[10] = '{7'b0100100, 1'b0, 7'b0000100, 7'b0000100, 1'b1, 1'b1};
    vt[11] = '{7'b0101000, 1'b0, 7'b0001000, 7'b0001000, 1'b1, 1'b1};
    vt[12] = '{7'b0100010, 1'b0, 7'b0100000, 7'b0100000, 1'b1, 1'b1};
    vt[13] = '{7'b1000010, 1'b0, 7'b1000000, 7'b1000000, 1'b1, 1'b1};
    vt[14] = '{7'b0000010, 1'b0, 7'b0000010, 7'b0000010, 1'b0, 1'b0};

    reset  = 1'b0;
    squash = 1'b0;
    apply(7'b1111110);
    @(posedge clock); #1;
    chk("rst_ack0", 64'(ack0.ack), 64'd0);
    chk("rst_valid0", 64'(cdb0[0].valid), 64'd0);
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_valid2", 64'({cdb2[1].valid, cdb2[0].valid}), 64'd0);
    apply(7'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    for (int r = 0; r < 15; r++) begin
      apply(vt[r].done);
      squash = vt[r].sq;
      @(negedge clock);
      chk($sformatf("row%0d.ack0", r), 64'(ack0.ack), 64'(vt[r].ack0));
      chk($sformatf("row%0d.ack1", r), 64'(ack1.ack), 64'(vt[r].ack1));
      @(posedge clock); #1;
      chk_pkt($sformatf("row%0d.cdb0", r), cdb0[0], vt[r].ack0);
      chk_pkt($sformatf("row%0d.cdb1", r), cdb1[0], vt[r].ack1);
      chk($sformatf("row%0d.busy0", r), 64'(busy0), 64'(vt[r].busy0));
      chk($sformatf("row%0d.busy1", r), 64'(busy1), 64'(vt[r].busy1));
    end
    squash = 1'b0;

    // FUs 1,2,5 hold done through reset; each drops done after its ack.
    reset = 1'b0;
    done  = 7'b0100110;
    apply(done);
    @(negedge clock);
    chk("s1.ack_in_reset", 64'(ack0.ack), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    seq = '{1, 2, 5};
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      chk($sformatf("s1.ack%0d", s), 64'(ack0.ack), 64'(7'd1 << seq[s]));
      @(posedge clock); #1;
      chk_pkt($sformatf("s1.cdb%0d", s), cdb0[0], 7'(7'd1 << seq[s]));
      done[seq[s]] = 1'b0;
      apply(done);
    end

    // Two slots: FU3 priority in slot 0, FU4 by rotation, then FU6 alone.
    do_reset();
    apply(7'b1011000);
    @(negedge clock);
    chk("s2.ack_a", 64'(ack2.ack), 64'(7'b0011000));
    @(posedge clock); #1;
    chk_pkt("s2.slot0_a", cdb2[0], 7'b0001000);
    chk_pkt("s2.slot1_a", cdb2[1], 7'b0010000);
    chk("s2.busy_a", 64'(busy2), 64'd1);
    apply(7'b1000000);
    @(negedge clock);
    chk("s2.ack_b", 64'(ack2.ack), 64'(7'b1000000));
    @(posedge clock); #1;
    chk_pkt("s2.slot0_b", cdb2[0], 7'b1000000);
    chk_pkt("s2.slot1_b", cdb2[1], 7'b0000000);
    chk("s2.busy_b", 64'(busy2), 64'd0);

    // Squash blocks FUs 1,5; afterwards FU1 broadcasts its value unchanged.
    do_reset();
    res[1] = 32'hDEADBEEF;
    apply(7'b0100010);
    squash = 1'b1;
    @(negedge clock);
    chk("s3.ack_sq", 64'(ack0.ack), 64'd0);
    @(posedge clock); #1;
    chk("s3.valid_sq", 64'(cdb0[0].valid), 64'd0);
    squash = 1'b0;
    @(negedge clock);
    chk("s3.ack", 64'(ack0.ack), 64'(7'b0000010));
    @(posedge clock); #1;
    chk_pkt("s3.cdb", cdb0[0], 7'b0000010);
    chk("s3.value", 64'(cdb0[0].value), 64'h0000_0000_DEAD_BEEF);

    // Reset pulse right after FU5's broadcast clears the bus asynchronously.
    do_reset();
    apply(7'b0100000);
    @(negedge clock);
    chk("s4.ack", 64'(ack0.ack), 64'(7'b0100000));
    @(posedge clock); #1;
    chk_pkt("s4.cdb", cdb0[0], 7'b0100000);
    #2 reset = 1'b0;
    #1;
    chk("s4.async_clear", 64'(cdb0[0]), 64'd0);
    chk("s4.ack_in_reset", 64'(ack0.ack), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("s4.regrant", 64'(ack0.ack), 64'(7'b0100000));
    @(posedge clock); #1;
    chk_pkt("s4.cdb_again", cdb0[0], 7'b0100000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Responder end of the FU done/ack handshake. Takes every FU's held result (done + rob_tag + value) and grants up to N_CDB of them per cycle on the common data bus.
- Returns a per-FU ack so each FU can free its output register and accept a new issue.
- Drives the registered CDB broadcast that the RS, ROB and map table consume.
- Sits between the execute stage and all CDB listeners.

Parameters:
- NUM_FU, 6: functional units, indexed 1..NUM_FU; index 0 is unused and never granted.
- N_CDB, 1: broadcast slots per cycle (1 or 2).
- PRIO_FU, 3: FU index given fixed priority over round-robin. 0 disables it. The load FU is prioritised because it holds the memory port.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ex_cdb_packet  in  EX_CDB_PACKET  fu_out_packets[NUM_FU:0], each carrying done, rob_tag, result, take_branch, branch_loc.
- squash  in  1  mispredict flush from retire.
- cdb_ex_packet  out  CDB_EX_PACKET  ack[NUM_FU:0], combinational grant per FU.
- cdb_packet  out  CDB_PACKET  [N_CDB-1:0] entries, each carrying valid, rob_tag, value. Registered.
- cdb_busy  out  1  registered: at least one requester was refused last cycle.

Behaviour:
- Reset (reset==0, async):
  - cdb_packet all zero, including valid=0.
  - cdb_busy=0.
  - rr_ptr=1.
  - ack combinationally 0 while reset is asserted.
- Request: req[i] = fu_out_packets[i].done for i in 1..NUM_FU. req[0] is forced to 0.
- Grant order, all combinational in the same cycle as req:
  1. PRIO_FU, if nonzero and requesting, takes slot 0.
  2. Remaining slots go to requesters in rotating order rr_ptr, rr_ptr+1, ..., wrapping NUM_FU -> 1 and skipping index 0.
- ack[i]=1 exactly for granted i. The FU holds done/result until the cycle ack is seen and may drop done in the next cycle.
- At most N_CDB acks per cycle. No FU is granted twice in one cycle.
- Broadcast: on the clock edge after a grant, cdb_packet[k] = {valid=1, rob_tag, value=result} of the FU granted slot k. Unused slots have valid=0. Latency from grant to broadcast is 1 cycle.
- Slot order: the PRIO_FU grant is always slot 0; the rest follow rotation order.
- rr_ptr update: if any round-robin grant occurred, rr_ptr = (last round-robin granted index mod NUM_FU) + 1. Otherwise rr_ptr holds. Grants to PRIO_FU do not move rr_ptr.
- Fairness: a continuously requesting non-priority FU is granted within ceil((NUM_FU-1)/N_CDB) cycles in which no PRIO_FU grant occurs.
- Branch FUs carry no special priority here. Branch resolution is taken directly from the FU outputs, not from the CDB.
- squash=1:
  - all acks forced to 0 that cycle;
  - the next-edge cdb_packet has all valid=0;
  - rr_ptr holds.
  - Results already registered are not recalled; a squash in the broadcast cycle is handled by the listeners.
- Empty (no req): acks 0, next cdb_packet all invalid, rr_ptr holds.
- Full (req count > N_CDB): only N_CDB acks are issued; refused FUs keep done high. cdb_busy is registered as 1.
- Reset deasserted mid-handshake: any FU still holding done is re-arbitrated from rr_ptr=1. No stale broadcast survives reset.
- rob_tag and value are copied unmodified. No width conversion.

Decomposition:
- Shared sys_defs package: NUM_FU, N_CDB, FU_OUT_PACKET, EX_CDB_PACKET, CDB_EX_PACKET, CDB_PACKET, ROB_TAG.
- One sub-module: rr_pick. It is a combinational rotating first-N selector taking req, ptr and mask, and returning a one-hot grant vector per slot.
- The top level holds rr_ptr, the output registers and the squash gating.

Test Plan:
- Reset with FUs 1,2,5 done, then deassert reset: cycle 0 ack={1}; next edge cdb rob_tag = FU1 tag; cycle 1 ack={2}; cycle 2 ack={5}.
- All six FUs done continuously, N_CDB=1, PRIO_FU=3: FU3 is acked every cycle; FUs 1,2,4,5,6 see no ack and cdb_busy=1. Repeat with PRIO_FU=0: acks follow 1,2,3,4,5,6,1, each exactly once per 6 cycles.
- N_CDB=2, FUs 3,4,6 done, rr_ptr=4: slot0=FU3 (prio), slot1=FU4. rr_ptr becomes 5. Next cycle FU6 is in slot0.
- squash asserted with FUs 1,5 done: no acks; next cdb valid=0. Squash deasserted: FU1 is acked and its rob_tag/value are broadcast unchanged (value 0xDEADBEEF).
- reset pulsed low while FU5 is granted: cdb_packet clears immediately, asynchronously. After release, FU5 is re-granted with its same rob_tag.
- Index 0 fu_out_packets.done=1 alone: never acked; cdb valid stays 0.
